// File: rtl/lsu_pkg.sv
// Shared types for the load/store sequencer: FSM states, RV32I funct3 codes
// and the access-size decode used by the controller and the lane datapath.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        ERR,
        RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_BAD
    } size_t;

    // Unsigned variants exist only for loads, so a store with BU/HU is illegal.
    function automatic size_t f3_size(input logic [2:0] f3, input logic we);
        size_t sz;
        case (f3)
            F3_B:    sz = SZ_B;
            F3_H:    sz = SZ_H;
            F3_W:    sz = SZ_W;
            F3_BU:   sz = we ? SZ_BAD : SZ_B;
            F3_HU:   sz = we ? SZ_BAD : SZ_H;
            default: sz = SZ_BAD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane.sv
// Combinational lane datapath: load extract with sign/zero extension and
// sub-word store merge into a previously read word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offs,
    input  size_t       size,
    input  logic        uns,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rd_word[{offs, 3'b000} +: 8];
        half_v = offs[1] ? rd_word[31:16] : rd_word[15:0];

        load_data = rd_word;
        case (size)
            SZ_B:    load_data = {{24{~uns & byte_v[7]}}, byte_v};
            SZ_H:    load_data = {{16{~uns & half_v[15]}}, half_v};
            default: load_data = rd_word;
        endcase

        store_data = old_word;
        case (size)
            SZ_B: store_data[{offs, 3'b000} +: 8] = wdata[7:0];
            SZ_H: begin
                if (offs[1]) store_data[31:16] = wdata[15:0];
                else         store_data[15:0]  = wdata[15:0];
            end
            SZ_W:    store_data = wdata;
            default: store_data = old_word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the execute stage and a word-addressed,
// single-port data memory (combinational read, synchronous write).
//
//   state  | meaning
//   IDLE   | ready for a request, memory bus parked at zero
//   LOAD   | read addressed word, extend selected lane into response
//   RMW_RD | read word to be merged by a sub-word store
//   WRITE  | single-cycle memory write of the full or merged word
//   ERR    | rejected access, no memory activity
//   RESP   | one-cycle response pulse
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    state_t      state, state_d;
    logic [31:0] addr_q, wdata_q, merge_q, rdata_q;
    logic [2:0]  f3_q;
    logic        we_q, err_q, mem_we_q;

    size_t       req_size, size_q;
    logic        accept, req_err;
    logic [31:0] load_data, store_data;

    assign req_size = f3_size(req_funct3, req_we);
    assign size_q   = f3_size(f3_q, we_q);
    assign accept   = req_valid & req_ready;

    assign req_err = (req_size == SZ_BAD)
                   | ((req_size == SZ_H) & req_addr[0])
                   | ((req_size == SZ_W) & (|req_addr[1:0]))
                   | (req_addr[31:2] >= 30'(MEM_WORDS));

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)              state_d = ERR;
                    else if (!req_we)         state_d = LOAD;
                    else if (req_size == SZ_W) state_d = WRITE;
                    else                      state_d = RMW_RD;
                end
            end
            LOAD:    state_d = RESP;
            RMW_RD:  state_d = WRITE;
            WRITE:   state_d = RESP;
            ERR:     state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            f3_q     <= '0;
            we_q     <= 1'b0;
            merge_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            mem_we_q <= 1'b0;
        end else begin
            state    <= state_d;
            mem_we_q <= (state_d == WRITE);
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
                we_q    <= req_we;
            end
            if (state == RMW_RD) merge_q <= mem_RD;
            // Response fields change only when a response is launched, so they hold in between.
            if (state_d == RESP) begin
                rdata_q <= (state == LOAD) ? load_data : '0;
                err_q   <= (state == ERR);
            end
        end
    end

    lsu_lane u_lane (
        .rd_word    (mem_RD),
        .old_word   (merge_q),
        .wdata      (wdata_q),
        .offs       (addr_q[1:0]),
        .size       (size_q),
        .uns        (f3_q[2]),
        .load_data  (load_data),
        .store_data (store_data)
    );

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q & resp_valid;
    assign mem_WE     = mem_we_q;
    assign mem_A      = (state == LOAD || state == RMW_RD || state == WRITE)
                        ? {addr_q[31:2], 2'b00} : '0;
    assign mem_WD     = (state == WRITE) ? store_data : '0;

endmodule
